// File: rtl/fc_layer_scheduler.sv
// fc_layer_scheduler: start/done sequencer for one fully-connected layer on
// the 8-lane MAC datapath. Walks output neurons tile by tile, streams every
// IFM element with one packed weight word, then drains the tile's
// accumulators downstream one lane at a time.
module fc_layer_scheduler #(
  parameter int IFM_SIZE    = 100,
  parameter int OFM_SIZE    = 80,
  parameter int TILING_SIZE = 8,
  parameter int ADDR_WIDTH  = 16,
  localparam int LANE_W     = (TILING_SIZE > 1) ? $clog2(TILING_SIZE) : 1
) (
  input  logic                  clk1,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  ifm_ready,
  input  logic                  wgt_avail,
  input  logic                  ofm_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  ifm_rd_en,
  output logic [ADDR_WIDTH-1:0] ifm_rd_addr,
  output logic                  wgt_read,
  output logic                  mac_en,
  output logic                  acc_clear,
  output logic                  drain_en,
  output logic [LANE_W-1:0]     drain_sel,
  output logic [15:0]           tile_idx
);

  // Layer geometry; the final tile may be partially populated.
  localparam int NUM_TILES  = (OFM_SIZE + TILING_SIZE - 1) / TILING_SIZE;
  localparam int LAST_LANES = OFM_SIZE - (NUM_TILES - 1) * TILING_SIZE;

  localparam logic [ADDR_WIDTH-1:0] K_LAST         = ADDR_WIDTH'(IFM_SIZE - 1);
  localparam logic [LANE_W-1:0]     LANE_FULL_LAST = LANE_W'(TILING_SIZE - 1);
  localparam logic [LANE_W-1:0]     LANE_TAIL_LAST = LANE_W'(LAST_LANES - 1);
  localparam logic [15:0]           TILE_LAST      = 16'(NUM_TILES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IFM,
    S_COMPUTE,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ADDR_WIDTH-1:0]   r_k;
  logic [LANE_W-1:0]       r_lane;
  logic [15:0]             r_tile;
  logic                    r_mac_en;
  logic                    r_acc_clear;

  logic                    w_issue;
  logic                    w_k_last;
  logic                    w_tile_last;
  logic                    w_lane_last;

  // One IFM element + one weight word leave the sources this cycle.
  assign w_issue     = (r_state == S_COMPUTE) && wgt_avail;
  assign w_k_last    = (r_k == K_LAST);
  assign w_tile_last = (r_tile == TILE_LAST);
  assign w_lane_last = w_tile_last ? (r_lane == LANE_TAIL_LAST)
                                   : (r_lane == LANE_FULL_LAST);

  // State register.
  always_ff @(posedge clk1) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_next_state
    // unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = ifm_ready ? S_COMPUTE : S_WAIT_IFM;
        end
      end
      S_WAIT_IFM: begin
        if (ifm_ready) begin
          w_next_state = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (w_issue && w_k_last) begin
          w_next_state = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (ofm_ready && w_lane_last) begin
          w_next_state = w_tile_last ? S_DONE : S_COMPUTE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Element, lane and tile counters; all return to zero by the time the
  // FSM is back in IDLE so idle outputs read as zero.
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_k    <= '0;
      r_lane <= '0;
      r_tile <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k    <= '0;
            r_lane <= '0;
            r_tile <= '0;
          end
        end
        S_COMPUTE: begin
          if (w_issue) begin
            r_k <= w_k_last ? '0 : r_k + ADDR_WIDTH'(1);
          end
        end
        S_FLUSH: begin
          r_lane <= '0;
        end
        S_DRAIN: begin
          if (ofm_ready) begin
            if (w_lane_last) begin
              r_lane <= '0;
              if (!w_tile_last) begin
                r_tile <= r_tile + 16'd1;
                r_k    <= '0;
              end
            end else begin
              r_lane <= r_lane + LANE_W'(1);
            end
          end
        end
        S_DONE: begin
          r_k    <= '0;
          r_lane <= '0;
          r_tile <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  // MAC enables trail the read strobe by the buffer's 1-cycle latency;
  // reset squashes whatever is in flight.
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_mac_en    <= 1'b0;
      r_acc_clear <= 1'b0;
    end else begin
      r_mac_en    <= w_issue;
      r_acc_clear <= w_issue && (r_k == '0);
    end
  end

  // Output decode from the current state.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    ifm_rd_en   = 1'b0;
    wgt_read    = 1'b0;
    drain_en    = 1'b0;
    drain_sel   = '0;
    case (r_state)
      S_IDLE: begin
      end
      S_WAIT_IFM, S_FLUSH: begin
        busy = 1'b1;
      end
      S_COMPUTE: begin
        busy      = 1'b1;
        ifm_rd_en = w_issue;
        wgt_read  = w_issue;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        drain_en  = 1'b1;
        drain_sel = r_lane;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign ifm_rd_addr = r_k;
  assign tile_idx    = r_tile;
  assign mac_en      = r_mac_en;
  assign acc_clear   = r_acc_clear;

endmodule

// File: tb/tb_fc_layer_scheduler.sv
// Directed bench for fc_layer_scheduler: two instances (16 and 12 output
// neurons, 4 IFM elements) share stimulus except for their start pulses.
module tb_fc_layer_scheduler;

  localparam int MON_MAX = 64;

  logic clk1;
  logic rst;
  logic start_a, start_b;
  logic ifm_ready, wgt_avail, ofm_ready;

  logic        a_busy, a_done, a_rd, a_wgt, a_mac, a_clr, a_den;
  logic [15:0] a_addr, a_tile;
  logic [2:0]  a_sel;
  logic        b_busy, b_done, b_rd, b_wgt, b_mac, b_clr, b_den;
  logic [15:0] b_addr, b_tile;
  logic [2:0]  b_sel;

  fc_layer_scheduler #(.IFM_SIZE(4), .OFM_SIZE(16), .TILING_SIZE(8), .ADDR_WIDTH(16)) dut_a (
    .clk1(clk1), .rst(rst), .start(start_a), .ifm_ready(ifm_ready),
    .wgt_avail(wgt_avail), .ofm_ready(ofm_ready), .busy(a_busy), .done(a_done),
    .ifm_rd_en(a_rd), .ifm_rd_addr(a_addr), .wgt_read(a_wgt), .mac_en(a_mac),
    .acc_clear(a_clr), .drain_en(a_den), .drain_sel(a_sel), .tile_idx(a_tile)
  );

  fc_layer_scheduler #(.IFM_SIZE(4), .OFM_SIZE(12), .TILING_SIZE(8), .ADDR_WIDTH(16)) dut_b (
    .clk1(clk1), .rst(rst), .start(start_b), .ifm_ready(ifm_ready),
    .wgt_avail(wgt_avail), .ofm_ready(ofm_ready), .busy(b_busy), .done(b_done),
    .ifm_rd_en(b_rd), .ifm_rd_addr(b_addr), .wgt_read(b_wgt), .mac_en(b_mac),
    .acc_clear(b_clr), .drain_en(b_den), .drain_sel(b_sel), .tile_idx(b_tile)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Monitored instance select.
  logic        mon_b;
  logic        m_busy, m_done, m_rd, m_wgt, m_mac, m_clr, m_den;
  logic [15:0] m_addr, m_tile;
  logic [2:0]  m_sel;
  assign m_busy = mon_b ? b_busy : a_busy;
  assign m_done = mon_b ? b_done : a_done;
  assign m_rd   = mon_b ? b_rd   : a_rd;
  assign m_wgt  = mon_b ? b_wgt  : a_wgt;
  assign m_mac  = mon_b ? b_mac  : a_mac;
  assign m_clr  = mon_b ? b_clr  : a_clr;
  assign m_den  = mon_b ? b_den  : a_den;
  assign m_addr = mon_b ? b_addr : a_addr;
  assign m_tile = mon_b ? b_tile : a_tile;
  assign m_sel  = mon_b ? b_sel  : a_sel;

  // Per-cycle trace, cycle 0 = first cycle after the start edge.
  logic        c_rd[MON_MAX], c_wgt[MON_MAX], c_mac[MON_MAX], c_clr[MON_MAX];
  logic        c_den[MON_MAX], c_acc[MON_MAX], c_done[MON_MAX], c_busy[MON_MAX];
  logic [15:0] c_addr[MON_MAX], c_tile[MON_MAX];
  logic [2:0]  c_sel[MON_MAX];
  int          m_len;

  // Trace summary.
  int n_rd, first_rd, n_mac, first_den, n_acc, last_acc, n_done, done_at, rd_ne_wgt;
  int q_addr[$], q_clr[$], q_sel[$], q_tile[$];

  int n_total = 0;
  int n_fail  = 0;
  int bad;
  int pat;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk1);
    #1;
  endtask

  // Runs the monitored instance from cycle 0 until one cycle after done,
  // dropping wgt_avail / ofm_ready over the given cycle windows.
  task automatic run_mon(input int wlo, input int whi, input int olo, input int ohi);
    int done_seen;
    done_seen = -1;
    m_len = 0;
    for (int c = 0; c < MON_MAX; c++) begin
      wgt_avail = !(c >= wlo && c <= whi);
      ofm_ready = !(c >= olo && c <= ohi);
      #1;
      c_rd[c]   = m_rd;   c_wgt[c]  = m_wgt; c_mac[c] = m_mac; c_clr[c] = m_clr;
      c_den[c]  = m_den;  c_acc[c]  = m_den && ofm_ready;
      c_done[c] = m_done; c_busy[c] = m_busy;
      c_addr[c] = m_addr; c_tile[c] = m_tile; c_sel[c] = m_sel;
      m_len = c + 1;
      cyc();
      if (done_seen >= 0 && c > done_seen) break;
      if (c_done[c]) done_seen = c;
    end
    wgt_avail = 1'b1;
    ofm_ready = 1'b1;
  endtask

  task automatic analyse();
    n_rd = 0; first_rd = -1; n_mac = 0; first_den = -1; n_acc = 0;
    last_acc = -1; n_done = 0; done_at = -1; rd_ne_wgt = 0;
    q_addr.delete(); q_clr.delete(); q_sel.delete(); q_tile.delete();
    for (int c = 0; c < m_len; c++) begin
      if (c_rd[c]) begin
        n_rd++;
        if (first_rd < 0) first_rd = c;
        q_addr.push_back(int'(c_addr[c]));
      end
      if (c_rd[c] !== c_wgt[c]) rd_ne_wgt++;
      if (c_mac[c]) begin
        n_mac++;
        if (c_clr[c]) q_clr.push_back(n_mac);
      end
      if (c_den[c] && first_den < 0) first_den = c;
      if (c_acc[c]) begin
        n_acc++;
        last_acc = c;
        q_sel.push_back(int'(c_sel[c]));
        q_tile.push_back(int'(c_tile[c]));
      end
      if (c_done[c]) begin
        n_done++;
        done_at = c;
      end
    end
  endtask

  task automatic pulse_start(input logic use_b);
    mon_b = use_b;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_idle_a(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!a_busy) break;
      cyc();
    end
    check(tag, int'(a_busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mon_b = 1'b0;
    ifm_ready = 1'b1; wgt_avail = 1'b1; ofm_ready = 1'b1;

    // Reset state.
    cyc(); cyc(); cyc();
    #1;
    check("rst_busy", int'(a_busy), 0);
    check("rst_outputs", int'({a_done, a_rd, a_wgt, a_mac, a_clr, a_den}), 0);
    check("rst_addr", int'(a_addr), 0);
    check("rst_sel_tile", int'(a_sel) + int'(a_tile), 0);
    check("rst_b_busy", int'(b_busy), 0);
    rst = 1'b0;
    cyc();

    // Two full tiles, everything ready.
    pulse_start(1'b0);
    run_mon(-1, -1, -1, -1);
    analyse();
    check("t1_rd_count", n_rd, 8);
    check("t1_first_issue", first_rd, 0);
    bad = 0;
    foreach (q_addr[i]) if (q_addr[i] != i % 4) bad++;
    check("t1_addr_seq_bad", bad, 0);
    check("t1_rd_eq_wgt_bad", rd_ne_wgt, 0);
    check("t1_mac_count", n_mac, 8);
    check("t1_clr_count", q_clr.size(), 2);
    pat = 0;
    foreach (q_clr[i]) pat = pat * 10 + q_clr[i];
    check("t1_clr_positions", pat, 15);
    check("t1_drain_count", n_acc, 16);
    bad = 0;
    foreach (q_sel[i]) if (q_sel[i] != i % 8 || q_tile[i] != i / 8) bad++;
    check("t1_lane_tile_seq_bad", bad, 0);
    check("t1_span", last_acc - first_rd + 1, 26);
    check("t1_done_at", done_at, 26);
    check("t1_done_pulses", n_done, 1);
    check("t1_idle_after", int'(c_busy[m_len-1]), 0);

    // Partial last tile on the 12-neuron instance.
    pulse_start(1'b1);
    run_mon(-1, -1, -1, -1);
    analyse();
    check("t2_rd_count", n_rd, 8);
    check("t2_drain_count", n_acc, 12);
    bad = 0;
    foreach (q_sel[i]) if (q_sel[i] != (i < 8 ? i : i - 8) || q_tile[i] != (i < 8 ? 0 : 1)) bad++;
    check("t2_lane_tile_seq_bad", bad, 0);
    check("t2_last_drain", last_acc, 21);
    check("t2_done_at", done_at, 22);
    mon_b = 1'b0;

    // Weight stall on the 2nd and 3rd COMPUTE cycles.
    pulse_start(1'b0);
    run_mon(1, 2, -1, -1);
    analyse();
    check("t3_stall_strobes", int'({c_rd[1], c_wgt[1], c_rd[2], c_wgt[2]}), 0);
    check("t3_addr_hold_c1", int'(c_addr[1]), 1);
    check("t3_addr_hold_c2", int'(c_addr[2]), 1);
    check("t3_mac_gap", int'({c_mac[1], c_mac[2], c_mac[3], c_mac[4], c_mac[5], c_mac[6]}), 6'b100111);
    bad = 0;
    for (int c = 0; c < 7; c++) if (c_rd[c]) bad++;
    check("t3_tile0_issues", bad, 4);
    check("t3_first_drain", first_den, 7);
    check("t3_rd_count", n_rd, 8);
    check("t3_done_at", done_at, 28);

    // Downstream backpressure on lane 5 of tile 0.
    pulse_start(1'b0);
    run_mon(-1, -1, 10, 12);
    analyse();
    bad = 0;
    for (int c = 10; c <= 13; c++) if (c_sel[c] != 3'd5 || !c_den[c]) bad++;
    check("t4_hold_lane5_bad", bad, 0);
    check("t4_drain_count", n_acc, 16);
    bad = 0;
    foreach (q_sel[i]) if (q_sel[i] != i % 8) bad++;
    check("t4_lane_seq_bad", bad, 0);
    check("t4_done_at", done_at, 29);

    // Start while the IFM buffer is not ready.
    ifm_ready = 1'b0;
    pulse_start(1'b0);
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (!a_busy || a_rd || a_wgt || a_mac) bad++;
      cyc();
    end
    check("t5_wait_bad", bad, 0);
    ifm_ready = 1'b1;
    #1;
    check("t5_no_rd_yet", int'(a_rd), 0);
    cyc();
    #1;
    check("t5_first_rd", int'(a_rd), 1);
    check("t5_first_addr", int'(a_addr), 0);
    wait_idle_a("t5_finishes", 60);
    cyc();

    // Reset mid-COMPUTE, with a start pulse while busy.
    pulse_start(1'b0);
    #1;
    check("t6_addr_c0", int'(a_addr), 0);
    cyc();
    start_a = 1'b1;
    #1;
    check("t6_addr_c1", int'(a_addr), 1);
    cyc();
    start_a = 1'b0;
    #1;
    check("t6_addr_c2_ignores_start", int'(a_addr), 2);
    rst = 1'b1;
    cyc();
    #1;
    check("t6_rst_flags", int'({a_busy, a_done, a_rd, a_wgt, a_mac, a_clr, a_den}), 0);
    check("t6_rst_addr", int'(a_addr), 0);
    check("t6_rst_sel_tile", int'(a_sel) + int'(a_tile), 0);
    rst = 1'b0;
    cyc();
    #1;
    check("t6_stays_idle", int'(a_busy), 0);
    cyc();
    pulse_start(1'b0);
    run_mon(-1, -1, -1, -1);
    analyse();
    check("t6_restart_addr0", (q_addr.size() > 0) ? q_addr[0] : -1, 0);
    check("t6_restart_tile0", int'(c_tile[0]), 0);
    check("t6_restart_done_at", done_at, 26);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule

// File: doc/fc_layer_scheduler.md
# fc_layer_scheduler

Sequencer for one fully-connected layer on the 8-lane MAC datapath. It walks the output neurons in tiles of TILING_SIZE. For each tile it streams every IFM element from the input buffer alongside one packed weight word per element. It then drains the tile's accumulators to the downstream stage one lane at a time. It sits between the IFM buffer / weight source and the PE array, replacing the free-running read strobes with a start/done controlled schedule.

## Interface
- IFM_SIZE, 100: input elements per output neuron (MAC steps per tile).
- OFM_SIZE, 80: output neurons in the layer; need not be a multiple of TILING_SIZE.
- TILING_SIZE, 8: lanes per tile (weights per packed weight word).
- ADDR_WIDTH, 16: IFM buffer address width; must cover IFM_SIZE-1.
- clk1  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle layer start request; honoured only in IDLE.
- ifm_ready  in  1  IFM buffer holds all IFM_SIZE elements.
- wgt_avail  in  1  weight source can supply a word this cycle.
- ofm_ready  in  1  downstream accepts the lane presented on drain_sel.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the layer completes.
- ifm_rd_en  out  1  IFM buffer read strobe (1-cycle read latency).
- ifm_rd_addr  out  ADDR_WIDTH  element index k being read.
- wgt_read  out  1  consume one packed weight word; always equal to ifm_rd_en.
- mac_en  out  1  PE array accumulates this cycle; ifm_rd_en delayed 1 cycle.
- acc_clear  out  1  with mac_en, load product instead of add (first element of tile).
- drain_en  out  1  lane drain_sel is presented downstream (valid_data).
- drain_sel  out  clog2(TILING_SIZE)  lane being drained.
- tile_idx  out  16  current tile number, 0-based.

## Operation
- NUM_TILES = ceil(OFM_SIZE/TILING_SIZE).
- LAST_LANES = OFM_SIZE - (NUM_TILES-1)*TILING_SIZE. Every other tile drains TILING_SIZE lanes.
- States: IDLE, WAIT_IFM, COMPUTE, FLUSH, DRAIN, DONE.
- IDLE: all outputs 0. On start, go to COMPUTE if ifm_ready, else WAIT_IFM. Clear k and tile_idx.
- WAIT_IFM: hold until ifm_ready=1, then go to COMPUTE.
- COMPUTE: in any cycle with wgt_avail=1, assert ifm_rd_en=wgt_read=1 with ifm_rd_addr=k, then k++. With wgt_avail=0, both strobes are 0 and k holds (stall bubble). An issue with k=IFM_SIZE-1 moves the FSM to FLUSH.
- mac_en(t) = ifm_rd_en(t-1). acc_clear(t) = ifm_rd_en(t-1) && addr(t-1)==0. Bubbles propagate, so mac_en has gaps.
- FLUSH: exactly 1 cycle; the final mac_en fires here. Then go to DRAIN with lane=0.
- DRAIN: drain_en=1 and drain_sel=lane. On ofm_ready=1, lane++. When the last lane (TILING_SIZE-1, or LAST_LANES-1 on the final tile) is accepted:
  - if more tiles remain, go to COMPUTE with tile_idx++ and k=0;
  - otherwise go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- start while busy is ignored. ifm_ready is sampled only in IDLE and WAIT_IFM; the buffer must stay stable for the whole layer.
- rst in any state: next cycle is IDLE, counters are 0, and all outputs are 0. In-flight mac_en is squashed.

## Timing
- Every output resets to 0; tile_idx resets to 0.
- start(t) with ifm_ready=1: first ifm_rd_en at t+1, first mac_en with acc_clear at t+2.
- Unstalled tile: IFM_SIZE issue cycles, then 1 FLUSH cycle, then lanes×1 drain cycles.
  - With ofm_ready=1 throughout, a full tile takes IFM_SIZE+1+TILING_SIZE cycles.
  - The next tile's first issue follows the last drain cycle immediately.
- Last drain accept at t, so DONE (done=1) at t+1 and IDLE at t+2.
- Defaults: 10 tiles, 1000 wgt_read pulses, 80 drain_en handshakes, 1090 cycles minimum from first issue to last drain.
- ifm_rd_en/wgt_read are never asserted outside COMPUTE. mac_en is never asserted outside COMPUTE/FLUSH.

## Test plan
- IFM_SIZE=4, OFM_SIZE=16, all ready high, start pulse:
  - addr 0,1,2,3 per tile and 8 wgt_read pulses total;
  - acc_clear on mac_en cycles 1 and 5 only;
  - drain_sel 0..7 twice, then done one cycle after the last drain;
  - 2×(4+1+8) cycles from first issue to last drain.
- IFM_SIZE=4, OFM_SIZE=12: second tile drains lanes 0..3 only; tile_idx goes 0 then 1; done follows lane 3.
- wgt_avail low on cycles 2 and 3 of COMPUTE: strobes drop, addr holds at 1, mac_en shows a 2-cycle gap, and the tile ends 2 cycles late with 4 issues.
- ofm_ready held low 3 cycles on lane 5: drain_sel stays 5 with drain_en=1, no lane is skipped, and the total handshake count is unchanged.
- start with ifm_ready=0: WAIT_IFM, busy=1, no strobes. Raising ifm_ready at t gives the first ifm_rd_en at t+1.
- rst asserted mid-COMPUTE (addr=2), and start pulsed while busy: rst gives all outputs 0 next cycle; start while busy has no effect. A fresh start then restarts at addr 0, tile 0.
